// File: rtl/seq_div4_pkg.sv
// rtl/seq_div4_pkg.sv - shared width constant and FSM state type for seq_div4
package seq_div4_pkg;

  localparam int DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca.sv
// rtl/rca.sv - ripple-carry adder, sum = a + b + cin with carry-out
module rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    cout = carry[W];
  end

endmodule

// File: rtl/seq_div4.sv
// rtl/seq_div4.sv - 4-bit sequential restoring divider, one quotient bit per cycle
import seq_div4_pkg::*;

module seq_div4 (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);

  state_t state, state_nxt;

  logic [DIV_W-1:0] dvd_q;
  logic [DIV_W-1:0] dvs_q;
  logic [DIV_W-1:0] prem_q;
  logic [DIV_W-1:0] quo_q;
  logic [1:0]       count_q;
  logic [DIV_W-1:0] quotient_q;
  logic [DIV_W-1:0] remainder_q;
  logic             dbz_q;

  logic [DIV_W:0]   trial;
  logic [DIV_W-1:0] diff;
  logic             carry_out;
  logic             diff_ge;
  logic [DIV_W-1:0] prem_nxt;
  logic [DIV_W-1:0] quo_nxt;
  logic             accept;
  logic             zero_dvs;
  logic             last_step;

  // Trial subtraction: trial[3:0] - divisor as trial + ~divisor + 1.
  assign trial = {prem_q, dvd_q[DIV_W-1]};

  rca #(.W(DIV_W)) u_sub (
    .a    (trial[DIV_W-1:0]),
    .b    (~dvs_q),
    .cin  (1'b1),
    .sum  (diff),
    .cout (carry_out)
  );

  assign diff_ge  = trial[DIV_W] | carry_out;
  assign prem_nxt = diff_ge ? diff : trial[DIV_W-1:0];
  assign quo_nxt  = {quo_q[DIV_W-2:0], diff_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    zero_dvs  = (divisor == '0);
    last_step = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = zero_dvs ? DONE : CALC;
        end
      end
      CALC: begin
        busy      = 1'b1;
        last_step = (count_q == 2'd0);
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      if (zero_dvs) begin
        quotient_q  <= '1;
        remainder_q <= dividend;
        dbz_q       <= 1'b1;
      end else begin
        dvd_q   <= dividend;
        dvs_q   <= divisor;
        prem_q  <= '0;
        quo_q   <= '0;
        count_q <= 2'd3;
        dbz_q   <= 1'b0;
      end
    end else if (state == CALC) begin
      dvd_q   <= {dvd_q[DIV_W-2:0], 1'b0};
      prem_q  <= prem_nxt;
      quo_q   <= quo_nxt;
      count_q <= count_q - 2'd1;
      // Results are published only once, on the final step, so they stay stable across CALC.
      if (last_step) begin
        quotient_q  <= quo_nxt;
        remainder_q <= prem_nxt;
      end
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div4.sv
// tb/tb_seq_div4.sv - randomized self-checking bench for seq_div4 against an arithmetic model
`timescale 1ns/1ps

module tb_seq_div4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_div4 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Issue one division and check latency, results, pulse width; optional
  // start pulse in a given CALC cycle and optional input noise while busy.
  task automatic run_div(input int a, input int b, input int pulse_cyc,
                         input bit noise, input string tag);
    int n;
    bit seen;
    int exp_q, exp_r, exp_z, exp_lat;
    if (b == 0) begin
      exp_q = 15; exp_r = a; exp_z = 1; exp_lat = 1;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_z = 0; exp_lat = 5;
    end
    @(negedge clk);
    start = 1'b1; dividend = a[3:0]; divisor = b[3:0];
    @(posedge clk);
    n = 1;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (pulse_cyc == n) begin
          start = 1'b1; dividend = 4'd1; divisor = 4'd1;
        end else if (noise) begin
          start    = 1'($urandom_range(0, 1));
          dividend = 4'($urandom);
          divisor  = 4'($urandom);
        end
        @(posedge clk);
        n++;
      end
    end
    chk({tag, "_latency"}, seen ? n : -1, exp_lat);
    chk({tag, "_quot"}, int'(quotient), exp_q);
    chk({tag, "_rem"}, int'(remainder), exp_r);
    chk({tag, "_dbz"}, int'(div_by_zero), exp_z);
    chk({tag, "_busy_in_done"}, int'(busy), 1);
    if (b != 0) begin
      chk({tag, "_invariant"}, int'(quotient) * b + int'(remainder), a);
      chk({tag, "_rem_lt_dvs"}, int'(int'(remainder) < b), 1);
    end
    @(negedge clk);
    chk({tag, "_done_width"}, int'(done), 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
    chk({tag, "_quot_hold"}, int'(quotient), exp_q);
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    #2;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quot", int'(quotient), 0);
    chk("reset_rem", int'(remainder), 0);
    chk("reset_dbz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_div(13, 3, 0, 1'b0, "d13_3");
    run_div(15, 1, 0, 1'b0, "d15_1");
    run_div(2, 9, 0, 1'b0, "d2_9");
    run_div(7, 0, 0, 1'b0, "d7_0");
    run_div(8, 2, 0, 1'b0, "d8_2");
    run_div(12, 5, 2, 1'b0, "d12_5_pulse");

    // Reset in CALC cycle 3 of 9/4.
    @(negedge clk);
    start = 1'b1; dividend = 4'd9; divisor = 4'd4;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quot", int'(quotient), 0);
    chk("abort_rem", int'(remainder), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_div(9, 4, 0, 1'b0, "d9_4_after_reset");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(a, b, 0, 1'b1, $sformatf("sweep_%0d_%0d", a, b));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
